// File: rtl/mux_pkg.sv
// Shared definitions for the arbitrating multiplexer: default sizes, the
// stats counter width, a constant clog2 and the output-register state type.
package mux_pkg;

    localparam int DEF_W   = 16;
    localparam int DEF_N   = 4;
    localparam int STATS_W = 16;

    // Number of bits needed to index n items (n >= 2 in this design).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // State of the one-entry output register; FULL is what out_valid shows.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/arb_mux_nxw_if.sv
// Bundle of the N-source / 1-sink handshake signals of arb_mux_nxw.
// Handshake: a word moves on any cycle where valid and ready are both high
// at the rising edge; a source holds data/valid until it sees ready.
// grant_count exists only when ARB_MUX_STATS_EN is defined.
interface arb_mux_nxw_if
    import mux_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) ();
    localparam int SW = clog2(N);

    logic [N*W-1:0]     in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [W-1:0]       out_data;
    logic [SW-1:0]      out_src;
    logic               out_valid;
    logic               out_ready;
    logic [SW-1:0]      dbg_ptr;     // round-robin pointer, for observation
`ifdef ARB_MUX_STATS_EN
    logic [STATS_W-1:0] grant_count;
`endif

    // Multiplexer side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_src, out_valid, dbg_ptr
`ifdef ARB_MUX_STATS_EN
        , output grant_count
`endif
    );

    // Producers/consumer side.
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_src, out_valid, dbg_ptr
`ifdef ARB_MUX_STATS_EN
        , input grant_count
`endif
    );

endinterface

// File: rtl/arb_mux_nxw_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr,
// wrapping N-1 -> 0. Works for any N (not only powers of two).
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N  = DEF_N,
    localparam int SW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [SW-1:0] gidx,
    output logic          any
);
    // One extra bit so ptr + k (at most 2N-2) never overflows before the wrap.
    localparam logic [SW:0] NW = (SW+1)'(N);

    logic [SW:0] idx;

    // Scan N positions starting at ptr; the first requester wins.
    always_comb begin
        grant = '0;
        gidx  = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, ptr} + (SW+1)'(k);
            if (idx >= NW) idx = idx - NW;
            if (!any && req[idx[SW-1:0]]) begin
                grant[idx[SW-1:0]] = 1'b1;
                gidx               = idx[SW-1:0];
                any                = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux_nxw.sv
// N-channel, W-bit arbitrating multiplexer with a registered output.
// A round-robin arbiter picks the source; the output register accepts a new
// word whenever it is empty or being drained in the same cycle.
// Optional feature: define ARB_MUX_STATS_EN to add the 16-bit grant_count.
module arb_mux_nxw
    import mux_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input logic         clk,
    input logic         reset,
    arb_mux_nxw_if.slave bus
);
    localparam int            SW   = clog2(N);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    out_state_t    state_q, state_d;
    logic [W-1:0]  data_q;
    logic [SW-1:0] src_q;
    logic [SW-1:0] ptr_q;
    logic [SW-1:0] ptr_nxt;
    logic [N-1:0]  grant;
    logic [SW-1:0] gidx;
    logic          any;
    logic          load;
    logic [W-1:0]  sel_data;

    rr_arbiter #(.N(N)) u_arb (
        .req   (bus.in_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .gidx  (gidx),
        .any   (any)
    );

    // Register may take a word when empty or when its word leaves this cycle.
    assign load    = (state_q == EMPTY) || bus.out_ready;
    assign ptr_nxt = (gidx == LAST) ? '0 : gidx + 1'b1;

    // Nothing is accepted while reset is held, even though the register is empty.
    assign bus.in_ready = (load && !reset) ? grant : '0;

    // Select the granted channel's data.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (gidx == SW'(i)) sel_data = bus.in_data[i*W +: W];
        end
    end

    // Next state of the output register: refilled or emptied on every load.
    always_comb begin
        state_d = state_q;
        if (load) state_d = any ? FULL : EMPTY;
    end

    // Output register occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    // Data, source tag and pointer move only when a channel is granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            src_q  <= '0;
            ptr_q  <= '0;
        end else if (load && any) begin
            data_q <= sel_data;
            src_q  <= gidx;
            ptr_q  <= ptr_nxt;
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    assign bus.dbg_ptr   = ptr_q;

`ifdef ARB_MUX_STATS_EN
    logic [STATS_W-1:0] grant_cnt_q;

    // Count input transfers; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             grant_cnt_q <= '0;
        else if (load && any)  grant_cnt_q <= grant_cnt_q + 1'b1;
    end

    assign bus.grant_count = grant_cnt_q;
`endif

endmodule
